// File: rtl/branch_seq.sv
// Fetch program-counter sequencer: sequential +2 advance, stall hold, taken-branch
// redirect through the shifted word offset, and a fixed-length wrong-path flush.
module branch_seq #(
  parameter int PC_W      = 6,
  parameter int FLUSH_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_off,
  input  logic [PC_W-1:0] br_pc,
  output logic [PC_W-1:0] pc,
  output logic            redirect,
  output logic            flush,
  output logic            br_ack
);

  typedef enum logic {RUN, FLUSH} state_e;

  localparam logic [2:0]      CNT_INIT = 3'(FLUSH_CYC - 1);
  localparam logic [PC_W-1:0] PC_STEP  = PC_W'(2);

  // Word offset becomes a byte offset; the offset MSB falls off the top.
  function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] base,
                                                     input logic [PC_W-1:0] off);
    return base + {off[PC_W-2:0], 1'b0};
  endfunction

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            redirect_q, redirect_d;
  logic            flush_q, flush_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc = pc_q + PC_STEP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= '0;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      flush_q    <= flush_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    flush_d    = flush_q;
    cnt_d      = cnt_q;
    br_ack     = br_valid & (state_q == RUN);
    unique case (state_q)
      RUN: begin
        if (br_valid && br_taken) begin
          pc_d       = branch_target(br_pc, br_off);
          redirect_d = 1'b1;
          flush_d    = 1'b1;
          cnt_d      = CNT_INIT;
          state_d    = FLUSH;
        end else if (!stall) begin
          pc_d = pc_inc;
        end
      end
      FLUSH: begin
        // Branches seen here are wrong-path; the drain length ignores stall.
        if (!stall) pc_d = pc_inc;
        if (cnt_q == 3'd0) begin
          flush_d = 1'b0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign pc       = pc_q;
  assign redirect = redirect_q;
  assign flush    = flush_q;

endmodule

// File: doc/branch_seq.md
# branch_seq

Program-counter sequencer for the pipelined core. It owns the 6-bit fetch PC and advances it by one instruction (2 bytes) per cycle. It holds the PC on a pipeline stall. On a taken branch it redirects fetch to the target, computed through the word-offset shift-left-by-one and the branch adder. After a redirect it asserts a flush for a fixed number of cycles so downstream stages squash wrong-path instructions.

## Interface
- PC_W, 6, width of PC, offset and target
- FLUSH_CYC, 2, cycles flush stays high after a redirect; legal range 1..7
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold PC (hazard unit)
- br_valid  in  1  branch resolved this cycle (EX stage)
- br_taken  in  1  branch outcome; qualified by br_valid
- br_off  in  PC_W  branch word offset (unsigned, modulo arithmetic)
- br_pc  in  PC_W  byte address of the branch instruction
- pc  out  PC_W  current fetch address (registered)
- redirect  out  1  one-cycle pulse: pc holds a branch target (registered)
- flush  out  1  squash wrong-path instructions (registered)
- br_ack  out  1  branch accepted this cycle (combinational)

## Operation
- States:
  - RUN: normal fetch.
  - FLUSH: wrong-path drain.
  - Internal counter cnt: 3 bits.
- Target computation:
  - shifted offset = {br_off[PC_W-2:0], 1'b0}; br_off MSB is discarded.
  - target = (br_pc + shifted offset) mod 2^PC_W.
  - Backward branches use wrap, e.g. br_off=011111 gives br_pc−2.
- Sequential increment: pc_next = (pc + 2) mod 2^PC_W; 62 → 0.
- br_ack = br_valid & (state==RUN).
  - br_valid in FLUSH is a wrong-path branch and is ignored: no ack, no PC effect.
- RUN, per edge, in priority order:
  1. br_valid & br_taken:
     - pc ← target, redirect ← 1, flush ← 1, cnt ← FLUSH_CYC−1, state ← FLUSH.
     - Overrides stall.
  2. stall: pc holds; redirect ← 0.
  3. Otherwise: pc ← pc_next; redirect ← 0.
  - br_valid & !br_taken: acked; behaves as case 2 or 3.
- FLUSH, per edge:
  - redirect ← 0.
  - pc ← pc_next unless stall, in which case pc holds.
  - If cnt==0: flush ← 0, state ← RUN. Otherwise cnt ← cnt−1.
  - cnt decrements regardless of stall.
- Reset values:
  - pc=0, redirect=0, flush=0, state=RUN, cnt=0.
  - br_ack follows its equation, so it is 0 unless br_valid.
- Reset mid-operation (including mid-FLUSH): all state returns to reset values immediately. No residual flush after rst falls.

## Timing
- PC advance latency: 1 cycle from edge to new pc.
- Redirect latency: branch sampled at edge E; pc=target and redirect=1 visible after E.
- flush is high for exactly FLUSH_CYC consecutive cycles, starting with the redirect cycle.
- First branch accepted after a flush: at the edge where flush falls to 0, state is RUN. br_ack may assert in that same cycle.
- Simultaneous events:
  - Taken branch + stall in RUN: redirect wins.
  - Stall in FLUSH: pc holds, but the flush length is unchanged.
- br_ack has no registered state. The requester samples it in the same cycle it drives br_valid; there is no retry.

## Test plan
- Reset then free-run, no stall or branch:
  - pc sequence 0,2,4,…,62,0 (wrap).
  - redirect and flush stay 0.
- Taken branch, br_pc=6, br_off=000110, FLUSH_CYC=2:
  - br_ack=1 in the request cycle.
  - Next cycle: pc=18 (6+12), redirect=1, flush=1.
  - Following cycle: pc=20, flush=1, redirect=0.
  - Then pc=22 with flush=0.
- Wrap and backward target:
  - br_pc=60, br_off=000100 → pc=4.
  - br_pc=10, br_off=011111 → pc=8.
  - br_off=100100 → same target as 000100.
- Not-taken and stall:
  - br_valid=1, br_taken=0 → br_ack=1, pc advances by 2.
  - stall for 3 cycles → pc constant, then resumes +2.
  - Taken branch with stall=1 → redirect still occurs.
- Branch during FLUSH: a second br_valid&br_taken one cycle after a redirect → br_ack=0, pc unaffected, flush ends on schedule.
- Async reset mid-FLUSH: assert rst between clock edges while flush=1 → pc=0, flush=0, redirect=0 immediately. After release, pc counts 2,4,… with no flush.
